// File: rtl/booths_divider.sv
// -----------------------------------------------------------------------------
// booths_divider
// Sequential radix-2 restoring divider, one quotient bit per clock. Shares the
// load/init/done/recieved handshake of the shift-add Booth multiplier so one
// controller can drive both blocks.
//
// Default build: two's-complement signed division, quotient truncated toward
// zero, remainder carries the dividend's sign.
// Macro BOOTHS_DIVIDER_UNSIGNED_EN: operands are unsigned, no sign fixup,
// ovf tied low; latency is unchanged.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   load     in   start request, sampled only in IDLE
//   recieved in   consumer ack, sampled only in DONE
//   A        in   N-bit dividend, held until init is seen high
//   B        in   N-bit divisor, held until init is seen high
//   done     out  result valid, held until recieved
//   init     out  one-cycle pulse: operands captured
//   Q        out  N-bit quotient, updated only in DONE
//   R        out  N-bit remainder, updated only in DONE
//   dbz      out  divide-by-zero flag, valid while done
//   ovf      out  signed overflow flag (-2^(N-1) / -1), valid while done
// -----------------------------------------------------------------------------
module booths_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         recieved,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         done,
    output logic         init,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         dbz,
    output logic         ovf
);

    localparam int CW = $clog2(N);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ITER  = 3'd2;
    localparam logic [2:0] S_FIXUP = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [N-1:0]  ZERO_N  = {N{1'b0}};
    localparam logic [N-1:0]  ONE_N   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  ONES_N  = {N{1'b1}};
    localparam logic [N-1:0]  MIN_N   = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    // Two's-complement negation helper
    function automatic logic [N-1:0] neg2(input logic [N-1:0] v);
        return ~v + ONE_N;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    acc_q, acc_d;         // partial remainder, N+1 bits wide
    logic [N-1:0]  qsr_q, qsr_d;         // dividend in, quotient bits out
    logic [N-1:0]  bmag_q, bmag_d;
    logic [N-1:0]  a_q, a_d;             // raw dividend for the dbz result
    logic          a_neg_q, a_neg_d;
    logic          q_neg_q, q_neg_d;
    logic          dbz_arm_q, dbz_arm_d;
    logic          ovf_arm_q, ovf_arm_d;
    logic [N-1:0]  q_res_q, q_res_d;
    logic [N-1:0]  r_res_q, r_res_d;
    logic          done_q, done_d;
    logic          init_q, init_d;
    logic [N-1:0]  q_out_q, q_out_d;
    logic [N-1:0]  r_out_q, r_out_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  a_mag_s, b_mag_s;
    logic          a_neg_s, q_neg_s, ovf_hit_s;
    logic [N+1:0]  acc_sh_s, trial_s;

    // Operand magnitudes and sign bookkeeping for the capture in INIT
    always_comb begin
`ifdef BOOTHS_DIVIDER_UNSIGNED_EN
        a_mag_s   = A;
        b_mag_s   = B;
        a_neg_s   = 1'b0;
        q_neg_s   = 1'b0;
        ovf_hit_s = 1'b0;
`else
        a_mag_s   = A[N-1] ? neg2(A) : A;
        b_mag_s   = B[N-1] ? neg2(B) : B;
        a_neg_s   = A[N-1];
        q_neg_s   = A[N-1] ^ B[N-1];
        ovf_hit_s = (A == MIN_N) && (B == ONES_N);
`endif
    end

    // Trial subtraction; the remainder is always below |B|, so its shifted
    // value is below 2^(N+1) and bit N+1 of the difference is a clean borrow.
    always_comb begin
        acc_sh_s = {acc_q, qsr_q[N-1]};
        trial_s  = acc_sh_s - {2'b00, bmag_q};
    end

    // Next-state and datapath logic keyed on the current state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        qsr_d     = qsr_q;
        bmag_d    = bmag_q;
        a_d       = a_q;
        a_neg_d   = a_neg_q;
        q_neg_d   = q_neg_q;
        dbz_arm_d = dbz_arm_q;
        ovf_arm_d = ovf_arm_q;
        q_res_d   = q_res_q;
        r_res_d   = r_res_q;
        done_d    = done_q;
        init_d    = 1'b0;
        q_out_d   = q_out_q;
        r_out_d   = r_out_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (load) begin
                    state_d = S_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                a_d       = A;
                bmag_d    = b_mag_s;
                qsr_d     = a_mag_s;
                acc_d     = {(N+1){1'b0}};
                cnt_d     = CNT_TOP;
                a_neg_d   = a_neg_s;
                q_neg_d   = q_neg_s;
                ovf_arm_d = ovf_hit_s;
                init_d    = 1'b1;
                done_d    = 1'b0;
                if (b_mag_s == ZERO_N) begin
                    dbz_arm_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    dbz_arm_d = 1'b0;
                    state_d   = S_ITER;
                end
            end
            S_ITER: begin
                if (!trial_s[N+1]) begin
                    acc_d = trial_s[N:0];
                end else begin
                    acc_d = acc_sh_s[N:0];
                end
                qsr_d = {qsr_q[N-2:0], ~trial_s[N+1]};
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_FIXUP;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_FIXUP: begin
                // For -2^(N-1)/-1 the magnitude quotient is already 2^(N-1)
                // and the signs match, so it wraps to -2^(N-1) with no negation.
                q_res_d = q_neg_q ? neg2(qsr_q) : qsr_q;
                r_res_d = a_neg_q ? neg2(acc_q[N-1:0]) : acc_q[N-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d = 1'b1;
                if (dbz_arm_q) begin
                    q_out_d = ONES_N;
                    r_out_d = a_q;
                    dbz_d   = 1'b1;
                    ovf_d   = 1'b0;
                end else begin
                    q_out_d = q_res_q;
                    r_out_d = r_res_q;
                    dbz_d   = 1'b0;
                    ovf_d   = ovf_arm_q;
                end
                if (recieved) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= CNT_ZERO;
            acc_q     <= {(N+1){1'b0}};
            qsr_q     <= ZERO_N;
            bmag_q    <= ZERO_N;
            a_q       <= ZERO_N;
            a_neg_q   <= 1'b0;
            q_neg_q   <= 1'b0;
            dbz_arm_q <= 1'b0;
            ovf_arm_q <= 1'b0;
            q_res_q   <= ZERO_N;
            r_res_q   <= ZERO_N;
            done_q    <= 1'b0;
            init_q    <= 1'b0;
            q_out_q   <= ZERO_N;
            r_out_q   <= ZERO_N;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            qsr_q     <= qsr_d;
            bmag_q    <= bmag_d;
            a_q       <= a_d;
            a_neg_q   <= a_neg_d;
            q_neg_q   <= q_neg_d;
            dbz_arm_q <= dbz_arm_d;
            ovf_arm_q <= ovf_arm_d;
            q_res_q   <= q_res_d;
            r_res_q   <= r_res_d;
            done_q    <= done_d;
            init_q    <= init_d;
            q_out_q   <= q_out_d;
            r_out_q   <= r_out_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign done = done_q;
    assign init = init_q;
    assign Q    = q_out_q;
    assign R    = r_out_q;
    assign dbz  = dbz_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_booths_divider.sv
// -----------------------------------------------------------------------------
// tb_booths_divider
// Directed self-checking bench for booths_divider (N=32). A behavioural model
// built on plain integer division supplies the expected result; a monitor
// compares Q/R/dbz/ovf against it on every cycle done is high. Directed
// vectors add hand-computed literals, latency, handshake and reset checks.
// -----------------------------------------------------------------------------
module tb_booths_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic        recieved;
    logic [31:0] A;
    logic [31:0] B;
    logic        done;
    logic        init;
    logic [31:0] Q;
    logic [31:0] R;
    logic        dbz;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q, exp_r;
    logic        exp_dbz, exp_ovf;
    logic        chk_en = 1'b0;

    booths_divider #(.N(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .recieved (recieved),
        .A        (A),
        .B        (B),
        .done     (done),
        .init     (init),
        .Q        (Q),
        .R        (R),
        .dbz      (dbz),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference result from plain integer arithmetic
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic d, output logic o);
        longint sa, sb;
        d = 1'b0;
        o = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            d = 1'b1;
        end else begin
`ifdef BOOTHS_DIVIDER_UNSIGNED_EN
            sa = {32'd0, a};
            sb = {32'd0, b};
`else
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            o  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`endif
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    // Result monitor: every cycle done is high the outputs must match the model
    always @(negedge clk) begin
        if (chk_en && done === 1'b1) begin
            chk("mon_Q", Q, exp_q);
            chk("mon_R", R, exp_r);
            chk("mon_dbz", {31'd0, dbz}, {31'd0, exp_dbz});
            chk("mon_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
        end
    end

    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        model(a, b, exp_q, exp_r, exp_dbz, exp_ovf);
        chk_en = 1'b1;
        @(negedge clk);
        A = a;
        B = b;
        load = 1'b1;
        @(posedge clk);   // edge 0
        #1;
        load = 1'b0;
    endtask

    // Count edges after edge 0 until done; optionally poke load/recieved mid-run
    task automatic wait_done(input int lat, input string nm, input bit glitch);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) chk({nm, "_init_hi"}, {31'd0, init}, 32'd1);
            if (cyc == 2) chk({nm, "_init_lo"}, {31'd0, init}, 32'd0);
            if (glitch) begin
                if (cyc == 6) begin
                    load = 1'b1;
                    A = 32'h0000_DEAD;
                end
                if (cyc == 7) load = 1'b0;
                if (cyc == 8) recieved = 1'b1;
                if (cyc == 9) recieved = 1'b0;
            end
        end
        chk({nm, "_latency"}, 32'(cyc), 32'(lat));
    endtask

    task automatic ack();
        recieved = 1'b1;
        @(posedge clk);
        #1;
        recieved = 1'b0;
        chk("ack_done_still_hi", {31'd0, done}, 32'd1);
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        chk("ack_done_clr", {31'd0, done}, 32'd0);
        chk("ack_Q_kept", Q, exp_q);
        chk("ack_R_kept", R, exp_r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        recieved = 1'b0;
        A = 32'd0;
        B = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_init", {31'd0, init}, 32'd0);
        chk("rst_Q", Q, 32'd0);
        chk("rst_R", R, 32'd0);
        chk("rst_dbz", {31'd0, dbz}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);

        // Basic positive division
        start_div(32'd100, 32'd7);
        wait_done(35, "d100_7", 1'b0);
        chk("d100_7_Q", Q, 32'd14);
        chk("d100_7_R", R, 32'd2);
        ack();

`ifndef BOOTHS_DIVIDER_UNSIGNED_EN
        start_div(-32'sd100, 32'd7);
        wait_done(35, "dm100_7", 1'b0);
        chk("dm100_7_Q", Q, 32'hFFFF_FFF2);
        chk("dm100_7_R", R, 32'hFFFF_FFFE);
        ack();

        start_div(32'd100, -32'sd7);
        wait_done(35, "d100_m7", 1'b0);
        chk("d100_m7_Q", Q, 32'hFFFF_FFF2);
        chk("d100_m7_R", R, 32'd2);
        ack();

        start_div(-32'sd100, -32'sd7);
        wait_done(35, "dm100_m7", 1'b0);
        chk("dm100_m7_Q", Q, 32'd14);
        chk("dm100_m7_R", R, 32'hFFFF_FFFE);
        ack();

        start_div(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(35, "ovf", 1'b0);
        chk("ovf_Q", Q, 32'h8000_0000);
        chk("ovf_R", R, 32'd0);
        chk("ovf_flag", {31'd0, ovf}, 32'd1);
        ack();

        // |A| = 2^31 must keep its MSB through the iteration
        start_div(32'h8000_0000, 32'd3);
        wait_done(35, "min_3", 1'b0);
        chk("min_3_Q", Q, 32'hD555_5556);
        chk("min_3_R", R, 32'hFFFF_FFFE);
        ack();
`else
        start_div(32'hFFFF_FFFF, 32'd2);
        wait_done(35, "umax_2", 1'b0);
        chk("umax_2_Q", Q, 32'h7FFF_FFFF);
        chk("umax_2_R", R, 32'd1);
        chk("umax_2_ovf", {31'd0, ovf}, 32'd0);
        ack();
`endif

        // Divide by zero: short path
        start_div(32'h1234_5678, 32'd0);
        wait_done(2, "dbz", 1'b0);
        chk("dbz_Q", Q, 32'hFFFF_FFFF);
        chk("dbz_R", R, 32'h1234_5678);
        chk("dbz_flag", {31'd0, dbz}, 32'd1);
        ack();

        // Dividend smaller than divisor
        start_div(32'd7, 32'd100);
        wait_done(35, "d7_100", 1'b0);
        chk("d7_100_Q", Q, 32'd0);
        chk("d7_100_R", R, 32'd7);
        ack();

        // load/recieved poked mid-division are ignored; done holds without ack
        start_div(32'd1000, 32'd10);
        wait_done(35, "glitch", 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("hold_done", {31'd0, done}, 32'd1);
        chk("hold_Q", Q, 32'd100);
        ack();

        // Back-to-back with load held high throughout
        model(32'd20, 32'd6, exp_q, exp_r, exp_dbz, exp_ovf);
        chk_en = 1'b1;
        @(negedge clk);
        A = 32'd20;
        B = 32'd6;
        load = 1'b1;
        @(posedge clk);
        #1;
        wait_done(35, "b2b1", 1'b0);
        chk("b2b1_Q", Q, 32'd3);
        chk("b2b1_R", R, 32'd2);
        recieved = 1'b1;
        @(posedge clk);   // DONE -> IDLE only
        #1;
        recieved = 1'b0;
        chk_en = 1'b0;
        A = 32'd50;
        B = 32'd8;
        model(32'd50, 32'd8, exp_q, exp_r, exp_dbz, exp_ovf);
        @(posedge clk);   // IDLE samples held load: new edge 0
        #1;
        chk("b2b_done_clr", {31'd0, done}, 32'd0);
        chk_en = 1'b1;
        load = 1'b0;
        wait_done(35, "b2b2", 1'b0);
        chk("b2b2_Q", Q, 32'd6);
        chk("b2b2_R", R, 32'd2);
        ack();

        // Reset in the middle of ITER
        start_div(32'd1000, 32'd10);
        chk_en = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_init", {31'd0, init}, 32'd0);
        chk("mid_rst_Q", Q, 32'd0);
        chk("mid_rst_R", R, 32'd0);
        chk("mid_rst_dbz", {31'd0, dbz}, 32'd0);
        chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("mid_rst_idle", {31'd0, done}, 32'd0);
        start_div(32'd9, 32'd3);
        wait_done(35, "d9_3", 1'b0);
        chk("d9_3_Q", Q, 32'd3);
        chk("d9_3_R", R, 32'd0);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booths_divider.md
Name: booths_divider

Overview:
Sequential radix-2 restoring divider. It is the inverse companion of the shift-add Booth multiplier and uses the same load/init/done/recieved handshake, so the existing controller drives both the same way. The block takes an N-bit dividend and an N-bit divisor and returns an N-bit quotient and an N-bit remainder, computing one quotient bit per clock.

Parameters:
- N, 32, operand, quotient and remainder width; must be >= 4.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset, sampled on the clk rising edge.
- load, input, 1, start request; sampled only in IDLE.
- recieved, input, 1, consumer ack; sampled only in DONE.
- A, input, N, dividend; must be held stable until init is seen high.
- B, input, N, divisor; must be held stable until init is seen high.
- done, output, 1, result valid; held high until recieved.
- init, output, 1, one-cycle pulse meaning operands captured.
- Q, output, N, quotient; registered and updated only in DONE.
- R, output, N, remainder; registered and updated only in DONE.
- dbz, output, 1, divide-by-zero flag; valid while done is high.
- ovf, output, 1, signed overflow flag; valid while done is high.

Behaviour:
- Reset: if rst_n=0 at a clk edge, the state goes to IDLE and done, init, Q, R, dbz and ovf all go to 0. Internal registers also clear. Reset takes effect from any state, including mid-division; there is no partial result.
- States: IDLE, INIT, ITER, FIXUP, DONE. The state register and the datapath update on the same edge and are keyed on the current state.
- IDLE:
  - Clears done and init.
  - Moves to INIT when load=1. Otherwise it stays in IDLE.
- INIT:
  - Captures the magnitudes |A| and |B|, the sign of A, and the sign of A xor B.
  - Sets counter=N-1, remainder accumulator=0, quotient shift register=|A|. Sets init=1 and done=0.
  - If B==0, goes to DONE with the divide-by-zero path armed. Otherwise goes to ITER.
- ITER (exactly N cycles):
  - Shift {acc, qsr} left by 1 and compute trial = acc_shifted - |B| at N+1 bits.
  - If trial >= 0: acc=trial and the new qsr LSB is 1. Otherwise acc is kept and the new qsr LSB is 0.
  - Clears init. Decrements counter. Goes to FIXUP when counter==0, otherwise stays in ITER.
- FIXUP:
  - Quotient is negated if the signs differed.
  - Remainder is negated if A was negative. This gives truncation toward zero and a remainder with the dividend's sign.
  - ovf=1 when A=-2^(N-1) and B=-1. In that case the quotient wraps to -2^(N-1) and R=0.
  - Goes to DONE.
- DONE:
  - Registers Q and R, sets done=1.
  - Divide-by-zero path: Q = all ones, R = A, dbz=1, ovf=0.
  - Goes to IDLE on recieved=1; done clears on the following edge. Otherwise holds done, Q and R.
- Latency, counting the edge that samples load in IDLE as edge 0:
  - init is high after edge 1.
  - done is high after edge N+3 (35 for N=32).
  - Divide-by-zero: done is high after edge 2.
- Boundary rules:
  - load is ignored outside IDLE; no queueing.
  - recieved is ignored outside DONE.
  - load and recieved both high in DONE: return to IDLE only; the new load is not honoured until it is sampled in IDLE.
  - Q and R keep their last values after leaving DONE, until the next DONE.
  - The ITER datapath is N+1 bits wide, so |A|=2^(N-1) does not lose its MSB.

Optional Feature:
- Macro BOOTHS_DIVIDER_UNSIGNED_EN.
- Defined: A and B are treated as unsigned; no magnitude or sign fixup is applied. FIXUP passes values through and still costs one cycle, so latency is unchanged. ovf is tied to 0.
- Undefined (default): two's-complement signed operation as described above.

Test Plan:
- A=100, B=7 -> after 35 edges: done=1, Q=14, R=2, dbz=0, ovf=0.
- A=-100, B=7 -> Q=-14 (0xFFFFFFF2), R=-2. Then A=100, B=-7 -> Q=-14, R=2. Then A=-100, B=-7 -> Q=14, R=-2.
- A=0x12345678, B=0 -> done after 2 edges with dbz=1, Q=0xFFFFFFFF, R=0x12345678. Then recieved=1 -> IDLE and done=0 on the next edge.
- A=0x80000000, B=0xFFFFFFFF (signed) -> Q=0x80000000, R=0, ovf=1. With BOOTHS_DIVIDER_UNSIGNED_EN: A=0xFFFFFFFF, B=2 -> Q=0x7FFFFFFF, R=1, ovf=0.
- Handshake: load pulsed during ITER has no effect. done stays high for 10 cycles with recieved=0. Back-to-back divisions with load held high give correct results.
- rst_n=0 for one edge during ITER (counter≈16) -> all outputs 0 and state IDLE. Then A=9, B=3 completes normally with Q=3, R=0.
